// File: rtl/wb_aperture_ctrl.sv
// Wishbone cycle controller between the AHB-to-FPGA bridge and four fabric
// clients (FPGA registers, UART0, UART1, QL reserved). Each bridge cycle is
// decoded to one 4 KB aperture. The selected client's cycle line is gated,
// and its ack and read data are returned to the bridge one cycle later.
// Unmapped or unanswered cycles end with DEFAULT_READ_VALUE, so the bridge
// can never hang.
//
// Handshake: the bridge holds WBs_CYC/WBs_STB/WBs_ADR stable from the strobe
// until WBs_ACK. A cycle is accepted only in IDLE. WBs_ACK is a registered
// single-cycle pulse, and WBs_RD_DAT is valid in that cycle and holds until
// the next load. A client finishes its cycle by raising its sl_ack_i bit
// while its sl_cyc_o bit is high. Dropping WBs_CYC before the ack abandons
// the cycle: no ack is returned and no error is counted.
module wb_aperture_ctrl #(
    parameter int                   APERWIDTH                = 17,
    parameter int                   APERSIZE                 = 10,
    parameter logic [APERWIDTH-1:0] FPGA_REG_BASE_ADDRESS    = 17'h00000,
    parameter logic [APERWIDTH-1:0] UART0_BASE_ADDRESS       = 17'h01000,
    parameter logic [APERWIDTH-1:0] UART1_BASE_ADDRESS       = 17'h02000,
    parameter logic [APERWIDTH-1:0] QL_RESERVED_BASE_ADDRESS = 17'h03000,
    parameter logic [31:0]          DEFAULT_READ_VALUE       = 32'hBAD_FAB_AC,
    parameter int                   DEFAULT_CNTR_WIDTH       = 3,
    parameter int                   DEFAULT_CNTR_TIMEOUT     = 7
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [APERWIDTH-1:0] WBs_ADR,
    input  logic                 WBs_CYC,
    input  logic                 WBs_STB,
    input  logic                 WBs_WE,
    output logic [31:0]          WBs_RD_DAT,
    output logic                 WBs_ACK,
    output logic [3:0]           sl_cyc_o,
    input  logic [3:0]           sl_ack_i,
    input  logic [31:0]          sl_rd_dat0_i,
    input  logic [31:0]          sl_rd_dat1_i,
    input  logic [31:0]          sl_rd_dat2_i,
    input  logic [31:0]          sl_rd_dat3_i,
    output logic                 timeout_o,
    output logic [7:0]           err_cnt_o,
    output logic [1:0]           fsm_state
);

    localparam int DEC_LSB = APERSIZE + 2;
    localparam logic [DEFAULT_CNTR_WIDTH-1:0] TIMEOUT_VAL =
        DEFAULT_CNTR_TIMEOUT[DEFAULT_CNTR_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                        state;
    logic [3:0]                    sel_q;
    logic [DEFAULT_CNTR_WIDTH-1:0] cntr;
    logic [3:0]                    hit;
    logic [31:0]                   sel_dat;

    // Byte-offset bits and the write flag do not affect the cycle sequence.
    logic unused_ok;
    assign unused_ok = &{1'b0, WBs_ADR[DEC_LSB-1:0], WBs_WE};

    // Aperture decode: compare the address page against each client base.
    always_comb begin
        hit    = 4'b0000;
        hit[0] = (WBs_ADR[APERWIDTH-1:DEC_LSB] == FPGA_REG_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
        hit[1] = (WBs_ADR[APERWIDTH-1:DEC_LSB] == UART0_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
        hit[2] = (WBs_ADR[APERWIDTH-1:DEC_LSB] == UART1_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
        hit[3] = (WBs_ADR[APERWIDTH-1:DEC_LSB] == QL_RESERVED_BASE_ADDRESS[APERWIDTH-1:DEC_LSB]);
    end

    // Read-data mux steered by the one-hot select captured at acceptance.
    always_comb begin
        sel_dat = ({32{sel_q[0]}} & sl_rd_dat0_i)
                | ({32{sel_q[1]}} & sl_rd_dat1_i)
                | ({32{sel_q[2]}} & sl_rd_dat2_i)
                | ({32{sel_q[3]}} & sl_rd_dat3_i);
    end

    // Only the selected client sees a cycle, and only while the bridge holds CYC.
    assign sl_cyc_o  = (state == ACTIVE) ? (sel_q & {4{WBs_CYC}}) : 4'b0000;
    assign fsm_state = state;

    // Cycle sequencer: accept, wait for the client or time out, ack once.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state      <= IDLE;
            sel_q      <= 4'b0000;
            cntr       <= '0;
            WBs_ACK    <= 1'b0;
            WBs_RD_DAT <= 32'h0;
            timeout_o  <= 1'b0;
            err_cnt_o  <= 8'h00;
        end else begin
            WBs_ACK   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (WBs_CYC && WBs_STB) begin
                        cntr <= '0;
                        if (hit != 4'b0000) begin
                            // Lowest-numbered match wins if bases ever overlap.
                            sel_q <= hit & (~hit + 4'b0001);
                            state <= ACTIVE;
                        end else begin
                            sel_q      <= 4'b0000;
                            WBs_RD_DAT <= DEFAULT_READ_VALUE;
                            WBs_ACK    <= 1'b1;
                            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                            state      <= DONE;
                        end
                    end
                end
                ACTIVE: begin
                    if (!WBs_CYC) begin
                        state <= IDLE;
                    end else if ((sl_ack_i & sel_q) != 4'b0000) begin
                        // A client ack wins over a timeout in the same cycle.
                        WBs_RD_DAT <= sel_dat;
                        WBs_ACK    <= 1'b1;
                        state      <= DONE;
                    end else if (cntr == TIMEOUT_VAL) begin
                        WBs_RD_DAT <= DEFAULT_READ_VALUE;
                        WBs_ACK    <= 1'b1;
                        timeout_o  <= 1'b1;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                        state      <= DONE;
                    end else begin
                        cntr <= cntr + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_aperture_ctrl.sv
// Bench for wb_aperture_ctrl. A transaction-level model predicts the ack
// latency, returned data, timeout pulses, selected client line and error
// count of each bridge cycle from the address map and the client's reply.
module tb_wb_aperture_ctrl;
    localparam logic [31:0] DEF_VAL = 32'hBADFABAC;

    // clock / reset
    logic        WB_CLK = 1'b0;
    logic        WB_RST;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC, WBs_STB, WBs_WE;
    logic [31:0] WBs_RD_DAT;
    logic        WBs_ACK;
    logic [3:0]  sl_cyc_o, sl_ack_i;
    logic [31:0] sl_rd_dat0_i, sl_rd_dat1_i, sl_rd_dat2_i, sl_rd_dat3_i;
    logic        timeout_o;
    logic [7:0]  err_cnt_o;
    logic [1:0]  fsm_state;

    always #5 WB_CLK = ~WB_CLK;

    wb_aperture_ctrl dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST), .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC),
        .WBs_STB(WBs_STB), .WBs_WE(WBs_WE), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .sl_cyc_o(sl_cyc_o), .sl_ack_i(sl_ack_i), .sl_rd_dat0_i(sl_rd_dat0_i),
        .sl_rd_dat1_i(sl_rd_dat1_i), .sl_rd_dat2_i(sl_rd_dat2_i), .sl_rd_dat3_i(sl_rd_dat3_i),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .fsm_state(fsm_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]  err_model;
    logic [31:0] exp_q[$];

    typedef struct packed {
        int          lat;
        logic [31:0] rd;
        int          to_cnt;
        int          cyc_cnt;
        logic [3:0]  cyc_or;
        logic [7:0]  err;
    } res_t;

    function automatic string fmt(input res_t r);
        return $sformatf("lat=%0d rd=%h to=%0d cyc=%0d sel=%b err=%h",
                         r.lat, r.rd, r.to_cnt, r.cyc_cnt, r.cyc_or, r.err);
    endfunction

    // Reference model: 4 KB pages 0..3 are the clients. A client that replies
    // within 7 wait states is acked after wait+2 cycles; otherwise the cycle is
    // forced at 9 cycles. Unmapped pages end after 1 cycle.
    function automatic res_t predict(input logic [16:0] addr, input int wait_n, input bit hold,
                                     input logic [3:0] mask, input logic [31:0] d [4],
                                     input logic [7:0] err_in);
        res_t r;
        int   idx;
        bit   mapped, acked;
        int   eff_wait;
        idx      = int'(addr) / 4096;
        mapped   = (idx < 4);
        acked    = 1'b0;
        eff_wait = 0;
        if (mapped && mask[idx]) begin
            if (hold) begin
                acked = 1'b1;
            end else if (wait_n >= 0 && wait_n <= 7) begin
                acked    = 1'b1;
                eff_wait = wait_n;
            end
        end
        r.lat     = !mapped ? 1 : (acked ? eff_wait + 2 : 9);
        r.rd      = acked ? d[idx] : DEF_VAL;
        r.to_cnt  = (mapped && !acked) ? 1 : 0;
        r.cyc_cnt = mapped ? r.lat - 1 : 0;
        r.cyc_or  = mapped ? (4'b0001 << idx) : 4'b0000;
        r.err     = acked ? err_in : ((err_in == 8'hFF) ? 8'hFF : err_in + 8'd1);
        return r;
    endfunction

    // driver: one bridge cycle, with the client replying after wait_n wait
    // states (or continuously when hold is set)
    task automatic run_txn(input logic [16:0] addr, input bit we, input int wait_n, input bit hold,
                           input logic [3:0] mask, input logic [31:0] d [4], output res_t o);
        int k;
        bit done;
        o = '0;
        sl_rd_dat0_i = d[0]; sl_rd_dat1_i = d[1]; sl_rd_dat2_i = d[2]; sl_rd_dat3_i = d[3];
        WBs_ADR = addr; WBs_WE = we; WBs_CYC = 1'b1; WBs_STB = 1'b1; sl_ack_i = 4'b0000;
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            @(posedge WB_CLK); #1;
            k++;
            if (timeout_o) o.to_cnt++;
            if (WBs_ACK) begin
                o.lat = k; o.rd = WBs_RD_DAT; o.err = err_cnt_o; done = 1'b1;
            end else begin
                if (sl_cyc_o != 4'b0000) o.cyc_cnt++;
                o.cyc_or = o.cyc_or | sl_cyc_o;
                sl_ack_i = (hold || k == wait_n + 1) ? mask : 4'b0000;
            end
        end
        WBs_CYC = 1'b0; WBs_STB = 1'b0; sl_ack_i = 4'b0000;
        if (!done) o.lat = -1;
        @(posedge WB_CLK); #1;
        if (WBs_ACK) o.lat = -2;
        if (timeout_o) o.to_cnt++;
    endtask

    task automatic test_reset();
        WB_RST = 1'b1; WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0; WBs_ADR = '0; sl_ack_i = '0;
        sl_rd_dat0_i = '0; sl_rd_dat1_i = '0; sl_rd_dat2_i = '0; sl_rd_dat3_i = '0;
        repeat (2) @(posedge WB_CLK);
        #1;
        n_checks++; if (WBs_ACK !== 1'b0) $display("FAIL reset_ack got=%b exp=0", WBs_ACK); else n_pass++;
        n_checks++; if (WBs_RD_DAT !== 32'h0) $display("FAIL reset_rd got=%h exp=0", WBs_RD_DAT); else n_pass++;
        n_checks++; if (sl_cyc_o !== 4'b0) $display("FAIL reset_cyc got=%b exp=0", sl_cyc_o); else n_pass++;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL reset_to got=%b exp=0", timeout_o); else n_pass++;
        n_checks++; if (err_cnt_o !== 8'h0) $display("FAIL reset_err got=%h exp=0", err_cnt_o); else n_pass++;
        n_checks++; if (fsm_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", fsm_state); else n_pass++;
        WB_RST = 1'b0;
        err_model = 8'h00;
    endtask

    task automatic test_uart0_wait();
        logic [31:0] d [4];
        res_t o, e;
        d = '{32'h1111_0000, 32'hA5A5_0001, 32'h2222_0000, 32'h3333_0000};
        e = predict(17'h01004, 2, 1'b0, 4'b0010, d, err_model);
        err_model = e.err;
        run_txn(17'h01004, 1'b0, 2, 1'b0, 4'b0010, d, o);
        n_checks++; if (o !== e) $display("FAIL uart0_wait got %s exp %s", fmt(o), fmt(e)); else n_pass++;
        n_checks++; if (o.lat !== 4 || o.rd !== 32'hA5A5_0001 || o.cyc_or !== 4'b0010 || o.err !== 8'h00)
            $display("FAIL uart0_wait_abs got %s exp lat=4 rd=a5a50001 sel=0010 err=00", fmt(o)); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [31:0] d [4];
        res_t o, e;
        d = '{32'h0, 32'h0, 32'hDEAD_0002, 32'h0};
        e = predict(17'h02000, -1, 1'b0, 4'b0000, d, err_model);
        err_model = e.err;
        run_txn(17'h02000, 1'b0, -1, 1'b0, 4'b0000, d, o);
        n_checks++; if (o !== e) $display("FAIL timeout got %s exp %s", fmt(o), fmt(e)); else n_pass++;
        n_checks++; if (o.lat !== 9 || o.rd !== DEF_VAL || o.to_cnt !== 1 || o.err !== 8'h01)
            $display("FAIL timeout_abs got %s exp lat=9 rd=badfabac to=1 err=01", fmt(o)); else n_pass++;
    endtask

    task automatic test_unmapped_write();
        logic [31:0] d [4];
        res_t o, e;
        d = '{32'h5, 32'h6, 32'h7, 32'h8};
        e = predict(17'h1F000, 0, 1'b1, 4'b1111, d, err_model);
        err_model = e.err;
        run_txn(17'h1F000, 1'b1, 0, 1'b1, 4'b1111, d, o);
        n_checks++; if (o !== e) $display("FAIL unmapped_write got %s exp %s", fmt(o), fmt(e)); else n_pass++;
        n_checks++; if (o.lat !== 1 || o.cyc_or !== 4'b0000 || o.err !== 8'h02)
            $display("FAIL unmapped_write_abs got %s exp lat=1 sel=0000 err=02", fmt(o)); else n_pass++;
    endtask

    task automatic test_ack_on_timeout();
        logic [31:0] d [4];
        res_t o, e;
        d = '{32'hC0DE_0007, 32'h0, 32'h0, 32'h0};
        e = predict(17'h00000, 7, 1'b0, 4'b0001, d, err_model);
        err_model = e.err;
        run_txn(17'h00000, 1'b0, 7, 1'b0, 4'b0001, d, o);
        n_checks++; if (o !== e) $display("FAIL ack_on_timeout got %s exp %s", fmt(o), fmt(e)); else n_pass++;
        n_checks++; if (o.rd !== 32'hC0DE_0007 || o.to_cnt !== 0 || o.err !== 8'h02 || o.lat !== 9)
            $display("FAIL ack_on_timeout_abs got %s exp rd=c0de0007 to=0 err=02 lat=9", fmt(o)); else n_pass++;
    endtask

    task automatic test_wrong_client_ack();
        logic [31:0] d [4];
        res_t o, e;
        d = '{32'h0, 32'h1234_5678, 32'h8765_4321, 32'h0};
        e = predict(17'h01000, 0, 1'b1, 4'b0100, d, err_model);
        err_model = e.err;
        run_txn(17'h01000, 1'b0, 0, 1'b1, 4'b0100, d, o);
        n_checks++; if (o !== e) $display("FAIL wrong_client_ack got %s exp %s", fmt(o), fmt(e)); else n_pass++;
        n_checks++; if (o.to_cnt !== 1 || o.rd !== DEF_VAL)
            $display("FAIL wrong_client_ack_abs got %s exp to=1 rd=badfabac", fmt(o)); else n_pass++;
    endtask

    task automatic test_reset_mid_active();
        logic [31:0] d [4];
        res_t o, e;
        WBs_ADR = 17'h02000; WBs_WE = 1'b0; WBs_CYC = 1'b1; WBs_STB = 1'b1; sl_ack_i = 4'b0000;
        repeat (3) @(posedge WB_CLK);
        #1;
        n_checks++; if (sl_cyc_o !== 4'b0100) $display("FAIL mid_active_cyc got=%b exp=0100", sl_cyc_o); else n_pass++;
        WB_RST = 1'b1;
        @(posedge WB_CLK); #1;
        n_checks++; if (fsm_state !== 2'd0 || WBs_ACK !== 1'b0 || WBs_RD_DAT !== 32'h0 || sl_cyc_o !== 4'b0 ||
                        timeout_o !== 1'b0 || err_cnt_o !== 8'h0)
            $display("FAIL mid_active_reset got state=%0d ack=%b rd=%h cyc=%b to=%b err=%h exp all 0",
                     fsm_state, WBs_ACK, WBs_RD_DAT, sl_cyc_o, timeout_o, err_cnt_o); else n_pass++;
        WB_RST = 1'b0; WBs_CYC = 1'b0; WBs_STB = 1'b0;
        err_model = 8'h00;
        @(posedge WB_CLK); #1;
        d = '{32'h0, 32'h0, 32'h0, 32'h0303_0303};
        e = predict(17'h03000, 1, 1'b0, 4'b1000, d, err_model);
        err_model = e.err;
        run_txn(17'h03000, 1'b0, 1, 1'b0, 4'b1000, d, o);
        n_checks++; if (o !== e) $display("FAIL after_reset_read got %s exp %s", fmt(o), fmt(e)); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d [4];
        res_t o, e;
        logic [16:0] addr;
        logic [3:0]  mask;
        int pick, wait_n;
        bit we;
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 5);
            if (pick < 4) addr = 17'(pick * 4096 + $urandom_range(0, 4095));
            else          addr = 17'($urandom_range(4, 31) * 4096 + $urandom_range(0, 4095));
            for (int j = 0; j < 4; j++) d[j] = $urandom;
            wait_n = $urandom_range(0, 9);
            we     = 1'($urandom_range(0, 1));
            mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : ((pick < 4) ? (4'b0001 << pick) : 4'b0000);
            e = predict(addr, wait_n, 1'b0, mask, d, err_model);
            err_model = e.err;
            exp_q.push_back(e.rd);
            run_txn(addr, we, wait_n, 1'b0, mask, d, o);
            e.rd = exp_q.pop_front();
            if (we && pick < 4) begin
                o.rd = 32'h0;
                e.rd = 32'h0;
            end
            n_checks++; if (o !== e) $display("FAIL random[%0d] adr=%h got %s exp %s", i, addr, fmt(o), fmt(e)); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        res_t o, e;
        time t0;
        d = '{32'hB2B_0000, 32'hB2B_0001, 32'hB2B_0002, 32'hB2B_0003};
        t0 = $time;
        for (int i = 0; i < 3; i++) begin
            e = predict(17'(i * 4096), 0, 1'b0, 4'b1111, d, err_model);
            err_model = e.err;
            run_txn(17'(i * 4096), 1'b0, 0, 1'b0, 4'b1111, d, o);
            n_checks++; if (o !== e) $display("FAIL back_to_back[%0d] got %s exp %s", i, fmt(o), fmt(e)); else n_pass++;
        end
        n_checks++; if ($time - t0 !== 90)
            $display("FAIL back_to_back_period got=%0t exp=90", $time - t0); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [31:0] d [4];
        res_t o, e;
        logic [16:0] addr;
        d = '{32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 300; i++) begin
            addr = 17'($urandom_range(4, 31) * 4096 + $urandom_range(0, 4095));
            e = predict(addr, 0, 1'b0, 4'b0000, d, err_model);
            err_model = e.err;
            run_txn(addr, 1'($urandom_range(0, 1)), 0, 1'b0, 4'b0000, d, o);
            n_checks++; if (o !== e) $display("FAIL saturation[%0d] got %s exp %s", i, fmt(o), fmt(e)); else n_pass++;
        end
        n_checks++; if (err_cnt_o !== 8'hFF) $display("FAIL saturation_final got=%h exp=ff", err_cnt_o); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_uart0_wait();
        test_timeout();
        test_unmapped_write();
        test_ack_on_timeout();
        test_wrong_client_ack();
        test_reset_mid_active();
        test_random();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
